// File: rtl/sevenseg_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver_pkg
//   Shared constants and types for the multiplexed 7-segment display driver.
//   Segment codes are active-low and packed as {g,f,e,d,c,b,a}.
//   No ports (package only).
// ---------------------------------------------------------------------------
package sevenseg_scan_driver_pkg;

  // Width of one BCD/hex digit in the packed data word.
  localparam int NIBBLE_W = 4;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal glyphs (legacy decoder codes).
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Hex glyphs A, b, C, d, E, F.
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Cathode-side drive for one digit slot.
  typedef struct packed {
    logic [6:0] seg_n;
    logic       dp_n;
  } seg_drive_t;

endpackage

// File: rtl/sevenseg_scan_driver_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
//   Combinational nibble -> active-low 7-segment code.
//   Ports:
//     nibble_i   [3:0]  digit value
//     hex_mode_i        1 = show 10..15 as A..F, 0 = show them as '0'
//     seg_n_o    [6:0]  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_hex_decode
  import sevenseg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_0;
    case (nibble_i)
      4'h0: seg_n_o = SEG_0;
      4'h1: seg_n_o = SEG_1;
      4'h2: seg_n_o = SEG_2;
      4'h3: seg_n_o = SEG_3;
      4'h4: seg_n_o = SEG_4;
      4'h5: seg_n_o = SEG_5;
      4'h6: seg_n_o = SEG_6;
      4'h7: seg_n_o = SEG_7;
      4'h8: seg_n_o = SEG_8;
      4'h9: seg_n_o = SEG_9;
      // Outside hex mode, 10..15 fall back to '0' like the old decoder did.
      4'hA: seg_n_o = hex_mode_i ? SEG_A : SEG_0;
      4'hB: seg_n_o = hex_mode_i ? SEG_B : SEG_0;
      4'hC: seg_n_o = hex_mode_i ? SEG_C : SEG_0;
      4'hD: seg_n_o = hex_mode_i ? SEG_D : SEG_0;
      4'hE: seg_n_o = hex_mode_i ? SEG_E : SEG_0;
      4'hF: seg_n_o = hex_mode_i ? SEG_F : SEG_0;
      default: seg_n_o = SEG_0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed multi-digit 7-segment driver. A packed word is captured
//   into a shadow register; one digit is lit per refresh slot, with all
//   anodes held off for the first GUARD_CYCLES of each slot to avoid ghosting.
//
//   load is a one-cycle strobe with no back-pressure: whenever load=1 on a
//   rising edge, data/dp/blank_mask are captured. There is no ready signal.
//
//   Ports:
//     clock       system clock, rising edge
//     resetn      asynchronous active-low reset
//     load        capture data/dp/blank_mask into the shadow
//     data        nibble i = digit i (digit 0 rightmost)
//     dp          1 = light decimal point of digit i
//     blank_mask  1 = force digit i dark
//     hex_mode    live: 1 = A..F glyphs, 0 = decimal only
//     lz_en       live: 1 = suppress leading zeros
//     seg_n       {g,f,e,d,c,b,a}, active-low, registered
//     dp_n        decimal point, active-low, registered
//     an_n        anode enables, active-low, at most one low, registered
// ---------------------------------------------------------------------------
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]          dp,
  input  logic [NUM_DIGITS-1:0]          blank_mask,
  input  logic                           hex_mode,
  input  logic                           lz_en,
  output logic [6:0]                     seg_n,
  output logic                           dp_n,
  output logic [NUM_DIGITS-1:0]          an_n
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;

  // Shadow of the CPU-side word
  logic [NIBBLE_W*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]          dp_q;
  logic [NUM_DIGITS-1:0]          blank_q;

  // Output register
  seg_drive_t            out_q, out_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Per-digit derived signals
  logic [NUM_DIGITS-1:0] zero_from;    // nibbles i..NUM_DIGITS-1 all zero
  logic [NUM_DIGITS-1:0] digit_blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            dec_seg;
  logic                  in_guard;

  // Prescaler and digit index
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero chain, built from the most significant digit downwards.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] =
      (data_q[(NUM_DIGITS-1)*NIBBLE_W +: NIBBLE_W] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (data_q[i*NIBBLE_W +: NIBBLE_W] == 4'h0);
    end
  end

  // Digit 0 is never zero-suppressed so a zero word still shows "0".
  always_comb begin
    digit_blank    = blank_q;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      digit_blank[i] = blank_q[i] | (lz_en & zero_from[i]);
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = data_q[i*NIBBLE_W +: NIBBLE_W];
        cur_dp    = dp_q[i];
        cur_blank = digit_blank[i];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble_i   (cur_nib),
    .hex_mode_i (hex_mode),
    .seg_n_o    (dec_seg)
  );

  // GUARD_CYCLES=0 makes this constantly false, disabling the guard window.
  assign in_guard = (int'(presc_q) < GUARD_CYCLES);

  // Next output word; everything is registered so a mid-slot load only
  // changes the display on a whole-cycle boundary.
  always_comb begin
    out_d.seg_n = SEG_BLANK;
    out_d.dp_n  = 1'b1;
    an_d        = '1;
    if (!in_guard) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IW'(i));
      end
      // A blank digit keeps its anode on but lights nothing, dp included.
      if (!cur_blank) begin
        out_d.seg_n = dec_seg;
        out_d.dp_n  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc_q     <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      out_q.seg_n <= SEG_BLANK;
      out_q.dp_n  <= 1'b1;
      an_q        <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (load) begin
        data_q  <= data;
        dp_q    <= dp;
        blank_q <= blank_mask;
      end
      out_q <= out_d;
      an_q  <= an_d;
    end
  end

  assign seg_n = out_q.seg_n;
  assign dp_n  = out_q.dp_n;
  assign an_n  = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Bench for sevenseg_scan_driver with a small geometry (4 digits, 8-cycle
//   slots, 2 guard cycles). The reference model derives every output from
//   the count of clock edges since reset plus a copy of the loaded word.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  localparam int N = 4;
  localparam int R = 8;
  localparam int G = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  logic           load;
  logic [4*N-1:0] data;
  logic [N-1:0]   dp;
  logic [N-1:0]   blank_mask;
  logic           hex_mode;
  logic           lz_en;
  logic [6:0]     seg_n;
  logic           dp_n;
  logic [N-1:0]   an_n;

  sevenseg_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blank_mask (blank_mask),
    .hex_mode   (hex_mode),
    .lz_en      (lz_en),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n)
  );

  // ---------------- reference model ----------------
  logic [6:0] code_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

  int             k;        // rising edges since reset release
  logic [4*N-1:0] m_data;   // model copy of the loaded word
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_blank;

  // Expected {an_n, seg_n, dp_n} once `edges` edges have elapsed, given the
  // word held in the model now (i.e. before the last of those edges).
  function automatic logic [11:0] model_out(input int edges);
    int             off, dig;
    logic [4*N-1:0] upper;
    logic [3:0]     nib;
    logic [3:0]     an;
    logic [6:0]     seg;
    logic           dpn;
    bit             blank;
    if (edges == 0) return {4'hF, 7'h7F, 1'b1};
    off = (edges - 1) % R;
    dig = ((edges - 1) / R) % N;
    if (off < G) return {4'hF, 7'h7F, 1'b1};
    an      = 4'hF;
    an[dig] = 1'b0;
    upper   = m_data >> (4 * dig);
    nib     = upper[3:0];
    blank   = m_blank[dig] || (lz_en && dig > 0 && upper == '0);
    if (blank) begin
      seg = 7'h7F;
      dpn = 1'b1;
    end else begin
      seg = (nib <= 4'd9 || hex_mode) ? code_tab[nib] : 7'h40;
      dpn = ~m_dp[dig];
    end
    return {an, seg, dpn};
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
               tag, obs, exp, k, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict, update model shadow, clock, compare.
  task automatic step();
    logic [11:0] e;
    exp_q.push_back(model_out(k + 1));
    if (load) begin
      m_data  = data;
      m_dp    = dp;
      m_blank = blank_mask;
    end
    @(posedge clock);
    #1;
    k++;
    e = exp_q.pop_front();
    check("an_n",  32'(an_n),  32'(e[11:8]));
    check("seg_n", 32'(seg_n), 32'(e[7:1]));
    check("dp_n",  32'(dp_n),  32'(e[0]));
  endtask

  // Step until the outputs show digit `dig` at slot offset `off`.
  task automatic run_to(input int dig, input int off);
    int tries;
    tries = 0;
    do begin
      step();
      tries++;
    end while (!(((k - 1) % R == off) && (((k - 1) / R) % N == dig))
               && tries <= N * R + 1);
    if (tries > N * R + 1) check("run_to_timeout", 32'(tries), 32'(N * R));
  endtask

  // Asynchronous reset pulse started between edges.
  task automatic do_reset();
    logic [11:0] e;
    resetn = 1'b0;
    #1;
    e = model_out(0);
    check("rst_an",  32'(an_n),  32'(e[11:8]));
    check("rst_seg", 32'(seg_n), 32'(e[7:1]));
    check("rst_dp",  32'(dp_n),  32'(e[0]));
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold_an",  32'(an_n),  32'hF);
    check("rst_hold_seg", 32'(seg_n), 32'h7F);
    resetn  = 1'b1;
    k       = 0;
    m_data  = '0;
    m_dp    = '0;
    m_blank = '0;
    exp_q.delete();
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] b);
    data       = d;
    dp         = p;
    blank_mask = b;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn     = 1'b1;
    load       = 1'b0;
    data       = '0;
    dp         = '0;
    blank_mask = '0;
    hex_mode   = 1'b0;
    lz_en      = 1'b0;
    k          = 0;
    m_data     = '0;
    m_dp       = '0;
    m_blank    = '0;
    #2;
    do_reset();

    // Empty shadow: digit 0 shows '0' after the guard, anodes rotate.
    run_to(0, G);
    check("boot_seg0", 32'(seg_n), 32'h40);
    run_to(1, G);
    check("boot_an1", 32'(an_n), 32'hD);

    // Slot geometry with 1234.
    do_reset();
    load_word(16'h1234, 4'h0, 4'h0);
    while (k < 3) step();
    check("d0_an",  32'(an_n),  32'hE);
    check("d0_seg", 32'(seg_n), 32'h19);
    while (k < 9) step();
    check("guard_an",  32'(an_n),  32'hF);
    check("guard_seg", 32'(seg_n), 32'h7F);
    while (k < 11) step();
    check("d1_an",  32'(an_n),  32'hD);
    check("d1_seg", 32'(seg_n), 32'h30);

    // Hex vs decimal for nibble B (hex_mode is live).
    hex_mode = 1'b1;
    load_word(16'h000B, 4'h0, 4'h0);
    run_to(0, G);
    check("hexB", 32'(seg_n), 32'h03);
    hex_mode = 1'b0;
    step();
    check("decB", 32'(seg_n), 32'h40);

    // Leading-zero suppression on 0050.
    lz_en = 1'b1;
    load_word(16'h0050, 4'h0, 4'h0);
    run_to(3, G);
    check("lz_d3", 32'(seg_n), 32'h7F);
    check("lz_d3_an", 32'(an_n), 32'h7);
    run_to(2, G);
    check("lz_d2", 32'(seg_n), 32'h7F);
    run_to(1, G);
    check("lz_d1", 32'(seg_n), 32'h12);
    run_to(0, G);
    check("lz_d0", 32'(seg_n), 32'h40);
    lz_en = 1'b0;
    run_to(3, G);
    check("nolz_d3", 32'(seg_n), 32'h40);

    // Blank mask overrides the decimal point.
    load_word(16'h5555, 4'b0010, 4'b0010);
    run_to(1, G);
    check("blank_seg", 32'(seg_n), 32'h7F);
    check("blank_dp",  32'(dp_n),  32'h1);
    check("blank_an",  32'(an_n),  32'hD);
    load_word(16'h5555, 4'b0001, 4'b0000);
    run_to(0, G);
    check("dp0", 32'(dp_n), 32'h0);
    run_to(1, G);
    check("dp1", 32'(dp_n), 32'h1);

    // Load on the wrap edge, then reset mid-slot.
    while (k % R != R - 1) step();
    load_word(16'h8888, 4'h0, 4'h0);
    run_to(((k - 1) / R) % N, G);
    check("wrap_load_seg", 32'(seg_n), 32'h00);
    repeat (2) step();
    #2;
    do_reset();
    run_to(0, G);
    check("rst_restart_an",  32'(an_n),  32'hE);
    check("rst_restart_seg", 32'(seg_n), 32'h40);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      data       = 16'($urandom) & mask;
      dp         = 4'($urandom_range(0, 15));
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      load       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        do_reset();
      end
      step();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
